mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage LoongArch32 core, sitting between the execute stage and the write-back stage. It latches the execute→memory bus, takes the synchronous data-SRAM read data, and performs byte/halfword select and sign/zero extension for loads. It produces the memory→write-back bus, a register-forwarding bus and a CSR-hazard bus for decode, and exception/ertn indications that squash younger memory traffic. It also buffers load data so that a write-back stall never loses the SRAM read result.

## Interface
- EXE_MEM_BUS_W, 189, width of the incoming bus. MSB→LSB fields: csr_we 1, csr_waddr 14, csr_wmask 32, csr_wdata 32, inst_ertn 1, exc_type 6, gr_we 1, res_from_mem 1, dest 5, pc 32, inst 32, exe_result 32.
- MEM_WB_BUS_W, 188, width of the outgoing bus. MSB→LSB fields: csr_we 1, csr_waddr 14, csr_wmask 32, csr_wdata 32, inst_ertn 1, exc_type 6, gr_we 1, dest 5, pc 32, inst 32, final_result 32.
- MEM_WR_BUS_W, 39, width of the forwarding bus. MSB→LSB fields: en_bypass 1, en_block 1, dest 5, final_result 32.
- MEM_CSR_BUS_W, 16, width of the CSR-hazard bus. MSB→LSB fields: csr_we_v 1, mem_ertn 1, csr_waddr 14.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- exe_mem_valid  in  1  execute stage offers an instruction.
- exe_mem_bus  in  EXE_MEM_BUS_W  instruction payload.
- mem_allowin  out  1  this stage can accept an instruction this cycle.
- data_sram_rdata  in  32  SRAM read data; valid in the first cycle the load occupies this stage.
- mem_wb_valid  out  1  instruction offered to write-back.
- wb_allowin  in  1  write-back accepts.
- mem_wb_bus  out  MEM_WB_BUS_W  payload to write-back.
- mem_wr_bus  out  MEM_WR_BUS_W  forwarding to decode.
- mem_csr_blk_bus  out  MEM_CSR_BUS_W  CSR hazard info to decode.
- mem_exc  out  1  valid instruction here carries an exception.
- mem_ertn  out  1  valid ertn here.
- wb_exc  in  1  flush from write-back exception.
- ertn_flush  in  1  flush from write-back ertn.

## Operation
- State consists of:
  - mem_valid.
  - bus_r, the latched payload.
  - rdata_buf (32 bits) and rdata_hold (1 bit).
- mem_ready_go is always 1.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- mem_wb_valid = mem_valid & mem_ready_go.
- mem_valid update, in priority order:
  - If ~resetn, 0.
  - Else if wb_exc | ertn_flush, 0.
  - Else if mem_allowin, mem_valid takes exe_mem_valid.
- bus_r is loaded when exe_mem_valid & mem_allowin; otherwise it holds.
- Load data source: ld_raw = rdata_hold ? rdata_buf : data_sram_rdata.
- rdata_buf/rdata_hold behaviour:
  - When mem_valid & res_from_mem & ~rdata_hold & ~wb_allowin, capture rdata_buf = data_sram_rdata and set rdata_hold = 1.
  - Clear rdata_hold when the instruction leaves (mem_wb_valid & wb_allowin), on flush, or on reset.
- Load type is taken from inst[24:22]: 000 ld.b, 001 ld.h, 010 ld.w, 100 ld.bu, 101 ld.hu.
- Byte/halfword select uses a = exe_result[1:0]:
  - Byte = ld_raw[8a+7 : 8a].
  - Half = a[1] ? ld_raw[31:16] : ld_raw[15:0].
  - ld.b and ld.h sign-extend; ld.bu and ld.hu zero-extend; ld.w passes all 32 bits.
- final_result = res_from_mem ? load_result : exe_result.
- exc_type and all other fields pass through unchanged. The stage does not generate new exceptions.
- mem_exc = mem_valid & |exc_type.
- mem_ertn = mem_valid & inst_ertn.
- Forwarding bus:
  - en_bypass = mem_valid & gr_we.
  - en_block = 0, because load data is resolved in this stage.
- CSR-hazard bus: csr_we_v = mem_valid & csr_we.

## Timing
- Reset values: mem_valid = 0, rdata_hold = 0. Therefore mem_wb_valid, mem_exc, mem_ertn, en_bypass and csr_we_v are all 0, and mem_allowin = 1. bus_r is don't-care, masked by mem_valid.
- Latency: an instruction accepted at edge N is visible on mem_wb_bus in cycle N+1. It leaves at the first edge where wb_allowin = 1.
- A flush wins over a simultaneous accept: exe_mem_valid & mem_allowin in the flush cycle leaves mem_valid = 0 after the edge.
- A load held for k stall cycles must present identical final_result in every cycle, even though data_sram_rdata changes after cycle 1.
- Back-to-back loads with no stall use data_sram_rdata directly; rdata_hold is never set.
- mem_exc and mem_ertn are combinational from registered state. They are asserted in the same cycle the instruction sits here, so execute can suppress the SRAM enable that cycle.

## Test plan
- Load widths: memory word 0x8087_F0F1.
  - ld.b, a = 0 → 0xFFFF_FFF1.
  - ld.bu, a = 3 → 0x0000_0080.
  - ld.h, a = 2 → 0xFFFF_8087.
  - ld.hu, a = 0 → 0x0000_F0F1.
  - ld.w → 0x8087_F0F1.
- Stall hold: ld.w with rdata 0x1234_5678, wb_allowin = 0 for 3 cycles while data_sram_rdata changes to 0xDEAD_BEEF. final_result stays 0x1234_5678, mem_allowin = 0, and the load exits on the cycle wb_allowin rises.
- Non-load: add with exe_result 0x0000_00AA and gr_we = 1, dest = 5. mem_wr_bus = {1, 0, 5, 0xAA} for one cycle, then mem_wb_bus carries the same result.
- Flush: valid instruction present, plus a new offer in the same cycle as wb_exc = 1. mem_valid = 0 next cycle and mem_wb_valid = 0.
- Exception/ertn: incoming exc_type = 6'b000100 → mem_exc = 1 while resident. inst_ertn = 1 → mem_ertn = 1 and mem_csr_blk_bus[14] = 1.
- Reset mid-stall: resetn = 0 for one edge during a held load. Afterwards mem_valid = 0, rdata_hold = 0 and mem_allowin = 1.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : LoongArch32 memory-access stage; load align/extend, stall-safe
//             load-data buffer, forwarding, CSR-hazard and exception outputs.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
    parameter int EXE_MEM_BUS_W = 189,
    parameter int MEM_WB_BUS_W  = 188,
    parameter int MEM_WR_BUS_W  = 39,
    parameter int MEM_CSR_BUS_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     exe_mem_valid,
    input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
    output logic                     mem_allowin,
    input  logic [31:0]              data_sram_rdata,
    output logic                     mem_wb_valid,
    input  logic                     wb_allowin,
    output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus,
    output logic [MEM_WR_BUS_W-1:0]  mem_wr_bus,
    output logic [MEM_CSR_BUS_W-1:0] mem_csr_blk_bus,
    output logic                     mem_exc,
    output logic                     mem_ertn,
    input  logic                     wb_exc,
    input  logic                     ertn_flush
);

    localparam logic c_mem_ready_go = 1'b1;

    localparam logic [2:0] c_ld_b  = 3'b000;
    localparam logic [2:0] c_ld_h  = 3'b001;
    localparam logic [2:0] c_ld_bu = 3'b100;
    localparam logic [2:0] c_ld_hu = 3'b101;

    logic                     r_mem_valid;
    logic [EXE_MEM_BUS_W-1:0] r_bus;
    logic [31:0]              r_rdata_buf;
    logic                     r_rdata_hold;

    logic        w_csr_we;
    logic [13:0] w_csr_waddr;
    logic [31:0] w_csr_wmask;
    logic [31:0] w_csr_wdata;
    logic        w_inst_ertn;
    logic [5:0]  w_exc_type;
    logic        w_gr_we;
    logic        w_res_from_mem;
    logic [4:0]  w_dest;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [31:0] w_exe_result;

    assign {w_csr_we, w_csr_waddr, w_csr_wmask, w_csr_wdata, w_inst_ertn, w_exc_type,
            w_gr_we, w_res_from_mem, w_dest, w_pc, w_inst, w_exe_result} = r_bus;

    logic w_flush;
    logic w_leave;

    assign w_flush      = wb_exc | ertn_flush;
    assign mem_allowin  = ~r_mem_valid | (c_mem_ready_go & wb_allowin);
    assign mem_wb_valid = r_mem_valid & c_mem_ready_go;
    assign w_leave      = mem_wb_valid & wb_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (w_flush) begin
            r_mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            r_mem_valid <= exe_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (exe_mem_valid && mem_allowin) begin
            r_bus <= exe_mem_bus;
        end
    end

    // SRAM data is only valid in the load's first cycle here; park it if WB stalls.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata_hold <= 1'b0;
        end else if (w_flush || w_leave) begin
            r_rdata_hold <= 1'b0;
        end else if (r_mem_valid && w_res_from_mem && !r_rdata_hold && !wb_allowin) begin
            r_rdata_hold <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_mem_valid && w_res_from_mem && !r_rdata_hold && !wb_allowin) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    logic [31:0] w_ld_raw;
    logic [1:0]  w_addr;
    logic [2:0]  w_ld_op;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_result;
    logic [31:0] w_final_result;

    assign w_ld_raw = r_rdata_hold ? r_rdata_buf : data_sram_rdata;
    assign w_addr   = w_exe_result[1:0];
    assign w_ld_op  = w_inst[24:22];
    assign w_half   = w_addr[1] ? w_ld_raw[31:16] : w_ld_raw[15:0];

    always_comb begin
        w_byte = w_ld_raw[7:0];
        case (w_addr)
            2'd0:    w_byte = w_ld_raw[7:0];
            2'd1:    w_byte = w_ld_raw[15:8];
            2'd2:    w_byte = w_ld_raw[23:16];
            default: w_byte = w_ld_raw[31:24];
        endcase
    end

    always_comb begin
        w_load_result = w_ld_raw;
        case (w_ld_op)
            c_ld_b:  w_load_result = {{24{w_byte[7]}}, w_byte};
            c_ld_h:  w_load_result = {{16{w_half[15]}}, w_half};
            c_ld_bu: w_load_result = {24'h0, w_byte};
            c_ld_hu: w_load_result = {16'h0, w_half};
            default: w_load_result = w_ld_raw;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_result : w_exe_result;

    assign mem_wb_bus = {w_csr_we, w_csr_waddr, w_csr_wmask, w_csr_wdata, w_inst_ertn,
                         w_exc_type, w_gr_we, w_dest, w_pc, w_inst, w_final_result};

    // Loads resolve here, so decode never needs to block on this stage.
    assign mem_wr_bus      = {r_mem_valid & w_gr_we, 1'b0, w_dest, w_final_result};
    assign mem_csr_blk_bus = {r_mem_valid & w_csr_we, w_inst_ertn, w_csr_waddr};

    assign mem_exc  = r_mem_valid & (|w_exc_type);
    assign mem_ertn = r_mem_valid & w_inst_ertn;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage with a queue-based reference.
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         exe_mem_valid;
    logic [188:0] exe_mem_bus;
    logic         mem_allowin;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [187:0] mem_wb_bus;
    logic [38:0]  mem_wr_bus;
    logic [15:0]  mem_csr_blk_bus;
    logic         mem_exc;
    logic         mem_ertn;
    logic         wb_exc;
    logic         ertn_flush;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .exe_mem_valid   (exe_mem_valid),
        .exe_mem_bus     (exe_mem_bus),
        .mem_allowin     (mem_allowin),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .mem_wb_bus      (mem_wb_bus),
        .mem_wr_bus      (mem_wr_bus),
        .mem_csr_blk_bus (mem_csr_blk_bus),
        .mem_exc         (mem_exc),
        .mem_ertn        (mem_ertn),
        .wb_exc          (wb_exc),
        .ertn_flush      (ertn_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [187:0] wb;
        logic [38:0]  wr;
        logic [15:0]  csr;
        logic         exc;
        logic         ertn;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string nm, input logic [187:0] act, input logic [187:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] op);
        logic [31:0] bb, hh;
        bb = (w >> (8 * a)) & 32'h0000_00FF;
        hh = (w >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            3'b000:  return bb[7]  ? (bb | 32'hFFFF_FF00) : bb;
            3'b001:  return hh[15] ? (hh | 32'hFFFF_0000) : hh;
            3'b100:  return bb;
            3'b101:  return hh;
            default: return w;
        endcase
    endfunction

    function automatic logic [188:0] mk_bus(input logic csr_we, input logic [13:0] waddr,
            input logic [31:0] wmask, input logic [31:0] wdata, input logic ertn,
            input logic [5:0] exc, input logic gr_we, input logic rfm, input logic [4:0] dest,
            input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] res);
        return {csr_we, waddr, wmask, wdata, ertn, exc, gr_we, rfm, dest, pc, inst, res};
    endfunction

    function automatic logic [31:0] ld_inst(input logic [2:0] op);
        return {7'h14, op, 22'h0};
    endfunction

    // Expected outputs of an instruction, given the SRAM word seen in its first cycle.
    function automatic exp_t mk_exp(input logic [188:0] b, input logic [31:0] w);
        exp_t e;
        logic [31:0] fin;
        fin    = b[101] ? load_val(w, b[1:0], b[56:54]) : b[31:0];
        e.wb   = {b[188:102], b[100:32], fin};
        e.wr   = {b[102], 1'b0, b[100:96], fin};
        e.csr  = {b[188], b[109], b[187:174]};
        e.exc  = |b[108:103];
        e.ertn = b[109];
        return e;
    endfunction

    // Monitor: compares whatever the stage presents against the scoreboard head.
    always @(negedge clk) begin
        if (resetn) begin
            check("mem_wb_valid", {187'h0, mem_wb_valid}, {187'h0, q.size() != 0});
            check("mem_allowin", {187'h0, mem_allowin}, {187'h0, (q.size() == 0) || wb_allowin});
            if (q.size() != 0) begin
                check("mem_wb_bus", mem_wb_bus, q[0].wb);
                check("mem_wr_bus", {149'h0, mem_wr_bus}, {149'h0, q[0].wr});
                check("mem_csr_blk_bus", {172'h0, mem_csr_blk_bus}, {172'h0, q[0].csr});
                check("mem_exc", {187'h0, mem_exc}, {187'h0, q[0].exc});
                check("mem_ertn", {187'h0, mem_ertn}, {187'h0, q[0].ertn});
                if (wb_allowin) void'(q.pop_front());
            end else begin
                check("idle_flags", {184'h0, mem_exc, mem_ertn, mem_wr_bus[38], mem_csr_blk_bus[15]},
                      188'h0);
            end
        end
    end

    task automatic set_in(input logic v, input logic [188:0] b, input logic wa,
                          input logic fe, input logic fr);
        exe_mem_valid = v;
        exe_mem_bus   = b;
        wb_allowin    = wa;
        wb_exc        = fe;
        ertn_flush    = fr;
        @(negedge clk);
    endtask

    task automatic tick(input logic [31:0] w);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        if (!resetn || wb_exc || ertn_flush) begin
            q.delete();
        end else if (exe_mem_valid && ((q.size() == 0) || wb_allowin)) begin
            q.push_back(mk_exp(exe_mem_bus, w));
            acc = 1'b1;
        end
        #1;
        data_sram_rdata = (acc && exe_mem_bus[101]) ? w : $urandom;
    endtask

    task automatic step(input logic v, input logic [188:0] b, input logic [31:0] w,
                        input logic wa, input logic fe, input logic fr);
        set_in(v, b, wa, fe, fr);
        tick(w);
    endtask

    function automatic logic [188:0] rand_bus();
        logic rfm;
        logic [31:0] inst;
        rfm  = $urandom_range(0, 1) == 1;
        inst = $urandom;
        if (rfm) inst[24:22] = ops[$urandom_range(0, 4)];
        return mk_bus($urandom_range(0, 3) == 0, 14'($urandom), $urandom, $urandom,
                      $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0,
                      $urandom_range(0, 1) == 1, rfm, 5'($urandom), $urandom, inst, $urandom);
    endfunction

    logic [31:0] ld_w_exp [5] = '{32'hFFFF_FFF1, 32'h0000_0080, 32'hFFFF_8087,
                                  32'h0000_F0F1, 32'h8087_F0F1};
    logic [2:0]  ld_w_op  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_w_a   [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};

    initial begin
        logic [188:0] b;
        resetn = 1'b0;
        data_sram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0);
        resetn = 1'b1;

        set_in(0, '0, 0, 0, 0);
        check("rst_allowin", {187'h0, mem_allowin}, {187'h0, 1'b1});
        check("rst_valid", {184'h0, mem_wb_valid, mem_exc, mem_ertn, mem_wr_bus[38]}, 188'h0);
        tick(0);

        for (int i = 0; i < 5; i++) begin
            b = mk_bus(0, 0, 0, 0, 0, 0, 1, 1, 5'd3, 32'h1c00_0000, ld_inst(ld_w_op[i]),
                       {30'h100, ld_w_a[i]});
            step(1, b, 32'h8087_F0F1, 1, 0, 0);
            set_in(0, '0, 1, 0, 0);
            check($sformatf("load_width%0d", i), {156'h0, mem_wb_bus[31:0]}, {156'h0, ld_w_exp[i]});
            tick(0);
        end

        b = mk_bus(0, 0, 0, 0, 0, 0, 1, 1, 5'd4, 32'h1c00_0010, ld_inst(3'b010), 32'h2000);
        step(1, b, 32'h1234_5678, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(0, '0, 0, 0, 0);
            check("stall_result", {156'h0, mem_wb_bus[31:0]}, {156'h0, 32'h1234_5678});
            check("stall_allowin", {187'h0, mem_allowin}, 188'h0);
            @(posedge clk);
            #1 data_sram_rdata = 32'hDEAD_BEEF;
        end
        set_in(0, '0, 1, 0, 0);
        check("stall_exit", {155'h0, mem_wb_valid, mem_wb_bus[31:0]}, {155'h1, 32'h1234_5678});
        tick(0);
        set_in(0, '0, 1, 0, 0);
        check("stall_gone", {187'h0, mem_wb_valid}, 188'h0);
        tick(0);

        b = mk_bus(0, 0, 0, 0, 0, 0, 1, 0, 5'd5, 32'h1c00_0020, 32'h0010_1000, 32'h0000_00AA);
        step(1, b, 0, 0, 0, 0);
        set_in(0, '0, 0, 0, 0);
        check("fwd_bus", {149'h0, mem_wr_bus}, {149'h0, 1'b1, 1'b0, 5'd5, 32'hAA});
        tick(0);
        set_in(0, '0, 1, 0, 0);
        check("add_wb", {151'h0, mem_wb_bus[100:96], mem_wb_bus[31:0]}, {151'h0, 5'd5, 32'hAA});
        tick(0);

        step(1, rand_bus(), $urandom, 0, 0, 0);
        set_in(1, rand_bus(), 1, 1, 0);
        tick($urandom);
        set_in(0, '0, 0, 0, 0);
        check("flush_valid", {186'h0, mem_wb_valid, mem_allowin}, {186'h0, 2'b01});
        tick(0);

        b = mk_bus(0, 0, 0, 0, 0, 6'b000100, 0, 0, 5'd0, 32'h1c00_0030, 32'h0, 32'h0);
        step(1, b, 0, 1, 0, 0);
        set_in(0, '0, 1, 0, 0);
        check("exc_flag", {187'h0, mem_exc}, {187'h0, 1'b1});
        tick(0);
        b = mk_bus(0, 14'h6, 0, 0, 1, 0, 0, 0, 5'd0, 32'h1c00_0034, 32'h0648_3800, 32'h0);
        step(1, b, 0, 1, 0, 0);
        set_in(0, '0, 1, 0, 0);
        check("ertn_flag", {186'h0, mem_ertn, mem_csr_blk_bus[14]}, {186'h0, 2'b11});
        tick(0);

        b = mk_bus(0, 0, 0, 0, 0, 0, 1, 1, 5'd6, 32'h1c00_0040, ld_inst(3'b010), 32'h3000);
        step(1, b, 32'h1111_2222, 0, 0, 0);
        set_in(0, '0, 0, 0, 0);
        resetn = 1'b0;
        tick(0);
        resetn = 1'b1;
        set_in(0, '0, 0, 0, 0);
        check("rst_stall", {186'h0, mem_wb_valid, mem_allowin}, {186'h0, 2'b01});
        tick(0);
        b = mk_bus(0, 0, 0, 0, 0, 0, 1, 1, 5'd7, 32'h1c00_0044, ld_inst(3'b010), 32'h3004);
        step(1, b, 32'h3333_4444, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            set_in(0, '0, i == 1, 0, 0);
            check("post_rst_load", {156'h0, mem_wb_bus[31:0]}, {156'h0, 32'h3333_4444});
            tick(0);
        end

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, rand_bus(), $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
